// File: rtl/regbank_writer.sv
// regbank_writer: in-order write-back buffer committing into an 8x16 register array with NZP update
// Ports: CLK/RESET (sync, active-high); WR_VALID/WR_READY handshake carrying DR, WR_DATA, LDCC;
//        REGISTER1/REGISTER2 select combinational SR1OUT/SR2OUT; NZP condition codes;
//        COUNT buffered entries, EMPTY when COUNT==0.
// Option: define REGBANK_WB_BYPASS_EN to let reads see the newest buffered write to the selected register.
module regbank_writer #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          WR_VALID,
    output logic          WR_READY,
    input  logic [2:0]    DR,
    input  logic [15:0]   WR_DATA,
    input  logic          LDCC,
    input  logic [2:0]    REGISTER1,
    input  logic [2:0]    REGISTER2,
    output logic [15:0]   SR1OUT,
    output logic [15:0]   SR2OUT,
    output logic [2:0]    NZP,
    output logic [AW:0]   COUNT,
    output logic          EMPTY
);
    logic [15:0]   r_regs [8];
    logic [2:0]    r_dr   [DEPTH];
    logic [15:0]   r_data [DEPTH];
    logic          r_ldcc [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [AW:0]   r_count;
    logic [2:0]    r_nzp;
    logic          w_push;
    logic          w_pop;
    logic [15:0]   w_head_data;

    assign WR_READY    = r_count != (AW+1)'(DEPTH);
    assign w_push      = WR_VALID && WR_READY;
    assign w_pop       = r_count != '0;
    assign w_head_data = r_data[r_head];
    assign COUNT       = r_count;
    assign EMPTY       = r_count == '0;
    assign NZP         = r_nzp;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < 8; i++) r_regs[i] <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_nzp   <= 3'b010;
        end else begin
            if (w_push) begin
                r_dr[r_tail]   <= DR;
                r_data[r_tail] <= WR_DATA;
                r_ldcc[r_tail] <= LDCC;
                r_tail         <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_regs[r_dr[r_head]] <= w_head_data;
                r_head               <= r_head + 1'b1;
                if (r_ldcc[r_head])
                    r_nzp <= w_head_data[15] ? 3'b100 : (w_head_data == '0) ? 3'b010 : 3'b001;
            end
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

`ifdef REGBANK_WB_BYPASS_EN
    // Walk from head to tail so the newest matching entry overrides older ones.
    always_comb begin
        SR1OUT = r_regs[REGISTER1];
        SR2OUT = r_regs[REGISTER2];
        for (int i = 0; i < DEPTH; i++) begin
            if ((AW+1)'(i) < r_count && r_dr[r_head + AW'(i)] == REGISTER1) SR1OUT = r_data[r_head + AW'(i)];
            if ((AW+1)'(i) < r_count && r_dr[r_head + AW'(i)] == REGISTER2) SR2OUT = r_data[r_head + AW'(i)];
        end
    end
`else
    assign SR1OUT = r_regs[REGISTER1];
    assign SR2OUT = r_regs[REGISTER2];
`endif
endmodule

// File: doc/regbank_writer.md
Name: regbank_writer

Overview:
Write side of the MCU register bank. Accepts register write-back requests (DR select, 16-bit data, condition-code update flag) on a valid/ready handshake and buffers them in a small in-order FIFO. Commits one entry per cycle into the 8x16 general-purpose register array and updates NZP. Owns the array and serves the two combinational source-register read ports consumed by the datapath.

Parameters:
DEPTH, 4, write-buffer entries; power of two, 2..16
AW, 2, log2(DEPTH); pointer width

Ports:
CLK  input  1  rising-edge clock
RESET  input  1  synchronous, active-high reset
WR_VALID  input  1  write request present
WR_READY  output  1  buffer can accept (not full)
DR  input  3  destination register index
WR_DATA  input  16  write-back data
LDCC  input  1  update NZP when this entry commits
REGISTER1  input  3  source register 1 index
REGISTER2  input  3  source register 2 index
SR1OUT  output  16  source register 1 data
SR2OUT  output  16  source register 2 data
NZP  output  3  condition codes {N,Z,P}
COUNT  output  AW+1  entries currently buffered
EMPTY  output  1  COUNT==0

Behaviour:
- Reset (RESET high at a CLK edge):
  - R0..R7 <= 0; FIFO pointers and COUNT <= 0; NZP <= 3'b010.
  - EMPTY=1, WR_READY=1, SR1OUT/SR2OUT=0 after reset.
  - Reset mid-operation discards all buffered entries; the handshake is ignored in the reset cycle.
- Handshake:
  - Push when WR_VALID && WR_READY at the edge; {DR, WR_DATA, LDCC} captured.
  - WR_READY = (COUNT != DEPTH), combinational from state only, never from WR_VALID.
  - A full buffer does not accept even if a pop occurs in the same cycle.
- Commit:
  - Every edge with COUNT>0 pops the head and writes R[head.DR] <= head.WR_DATA.
  - If head.LDCC is set: NZP <= 100 if data[15]; 010 if data==0; else 001.
  - If head.LDCC is clear, NZP holds.
  - Simultaneous push and pop: COUNT unchanged, both take effect.
- Latency: request accepted at edge t is committed at edge t+1 when the buffer was empty before t. In general, commit happens COUNT-at-push edges later. Order is strictly FIFO.
- Same-register writes: multiple pending writes to one DR commit in order; the last one wins.
- Pointers wrap modulo DEPTH. COUNT saturates neither way: a push when full is impossible; a pop when empty does not occur.
- Reads: SR1OUT = R[REGISTER1] and SR2OUT = R[REGISTER2], combinational. Both ports may select the same register. R0 is an ordinary writable register.
- COUNT and EMPTY are registered-state derived; no glitch from inputs.

Optional Feature:
- Macro: REGBANK_WB_BYPASS_EN.
- Defined: SRnOUT returns the newest buffered entry whose DR matches REGISTERn, searched from tail toward head. If no entry matches, it returns the array value. A write becomes readable the cycle after acceptance.
- Undefined: SRnOUT reads the array only. A write becomes readable after its commit edge.
- Handshake, commit order and NZP timing are identical in both builds.

Test Plan:
- Reset: drive RESET 1 cycle after random writes -> all SRnOUT=0, NZP=010, COUNT=0, EMPTY=1, WR_READY=1.
- Single write: push DR=3, data=16'h1234, LDCC=1 into an empty buffer -> R3=1234 one edge later, NZP=001, COUNT returns to 0.
- Full/backpressure: hold WR_VALID for DEPTH+2 cycles while commits drain one per cycle.
  - Pushes continue only while WR_READY=1.
  - No entry is lost or duplicated.
  - Final R values match pushes in order.
- Same register: back-to-back writes to R5 of 8000 (LDCC=1) then 0000 (LDCC=1) -> NZP goes 100 then 010, final R5=0000. With LDCC=0 on the second write, NZP stays 100.
- Bypass: push DR=2, data=BEEF with REGISTER1=2.
  - BYPASS build: SR1OUT=BEEF the cycle after acceptance.
  - Non-bypass build: SR1OUT=BEEF only after the commit edge.
- Reset mid-operation: 3 entries buffered, assert RESET -> entries discarded, no register written by them, COUNT=0.
